async_fifo_wr_arbiter: RTL

Round-robin write-port arbiter that shares the single write port of one `async_fifo` instance between `NREQ` event sources in the same clock domain. The write side of the FIFO is clocked by `clk`. Each accepted word is tagged with its source index so the read domain can demultiplex. Per-grant bursts are capped, the FIFO's `wfull` back-pressure is honoured, and write and stall statistics are kept.

---
 rtl/async_fifo_wr_arbiter_if.sv | 37 +++
 rtl/async_fifo_wr_arbiter.sv | 138 +++++++++++++
 2 files changed

// File: rtl/async_fifo_wr_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module  : async_fifo_wr_arbiter_if
// Brief   : Requester/FIFO-write bundle between event sources and the arbiter.
// Revision: 1.0 - initial release
// ============================================================================
interface async_fifo_wr_arbiter_if #(
    parameter int NREQ  = 4,
    parameter int DSIZE = 8
);
    localparam int IDW = $clog2(NREQ);

    logic                   enable;
    logic [NREQ-1:0]        req_valid;
    logic [NREQ*DSIZE-1:0]  req_data;
    logic [NREQ-1:0]        req_ready;
    logic                   fifo_wreq;
    logic [IDW+DSIZE-1:0]   fifo_wdata;
    logic                   fifo_wfull;
    logic [IDW-1:0]         owner;
    logic                   busy;
    logic [15:0]            wr_count;
    logic [15:0]            stall_count;

    // Requesters and FIFO flag side
    modport master (
        output enable, req_valid, req_data, fifo_wfull,
        input  req_ready, fifo_wreq, fifo_wdata, owner, busy, wr_count, stall_count
    );

    // Arbiter side
    modport slave (
        input  enable, req_valid, req_data, fifo_wfull,
        output req_ready, fifo_wreq, fifo_wdata, owner, busy, wr_count, stall_count
    );
endinterface
`default_nettype wire

// File: rtl/async_fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : async_fifo_wr_arbiter
// Brief   : Round-robin, burst-capped sharing of one async FIFO write port.
// Revision: 1.0 - initial release
// ============================================================================
module async_fifo_wr_arbiter #(
    parameter int NREQ  = 4,
    parameter int DSIZE = 8,
    parameter int BURST = 4
) (
    input  wire logic             clk,
    input  wire logic             rst,
    async_fifo_wr_arbiter_if.slave bus
);
    localparam int              IDW        = $clog2(NREQ);
    localparam logic [7:0]      c_BCNT_END = 8'(BURST - 1);
    localparam logic [15:0]     c_CNT_MAX  = 16'hFFFF;
    localparam logic [IDW-1:0]  c_LAST_RST = IDW'(NREQ - 1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_OWN  = 1'b1
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [IDW-1:0]  r_owner;
    logic [IDW-1:0]  w_owner_nxt;
    logic [IDW-1:0]  r_last;
    logic [IDW-1:0]  w_last_nxt;
    logic [7:0]      r_bcnt;
    logic [7:0]      w_bcnt_nxt;
    logic [15:0]     r_wr_count;
    logic [15:0]     w_wr_count_nxt;
    logic [15:0]     r_stall_count;
    logic [15:0]     w_stall_count_nxt;

    logic [DSIZE-1:0] w_data [NREQ];
    logic [IDW-1:0]   w_cand;
    logic [IDW-1:0]   w_pick;
    logic             w_found;
    logic             w_own;
    logic             w_owner_valid;
    logic             w_write;

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
            assign w_data[gi] = bus.req_data[gi*DSIZE +: DSIZE];
        end
    endgenerate

    // Search starts one past the previous owner; IDW-bit wrap gives the modulo.
    always_comb begin
        w_cand  = r_last;
        w_pick  = r_last;
        w_found = 1'b0;
        for (int i = 1; i <= NREQ; i++) begin
            w_cand = r_last + IDW'(i);
            if (!w_found && bus.req_valid[w_cand]) begin
                w_pick  = w_cand;
                w_found = 1'b1;
            end
        end
    end

    assign w_own         = (r_state == S_OWN);
    assign w_owner_valid = bus.req_valid[r_owner];
    assign w_write       = w_own & bus.enable & w_owner_valid & ~bus.fifo_wfull;

    assign bus.fifo_wreq   = w_write;
    assign bus.req_ready   = w_write ? (NREQ'(1) << r_owner) : '0;
    assign bus.fifo_wdata  = w_own ? {r_owner, w_data[r_owner]} : '0;
    assign bus.owner       = r_owner;
    assign bus.busy        = w_own;
    assign bus.wr_count    = r_wr_count;
    assign bus.stall_count = r_stall_count;

    always_comb begin
        w_state_nxt       = r_state;
        w_owner_nxt       = r_owner;
        w_last_nxt        = r_last;
        w_bcnt_nxt        = r_bcnt;
        w_wr_count_nxt    = r_wr_count;
        w_stall_count_nxt = r_stall_count;
        case (r_state)
            S_IDLE: begin
                if (bus.enable && w_found) begin
                    w_owner_nxt = w_pick;
                    w_state_nxt = S_OWN;
                end
            end
            S_OWN: begin
                if (!bus.enable || !w_owner_valid) begin
                    w_state_nxt = S_IDLE;
                    w_last_nxt  = r_owner;
                    w_bcnt_nxt  = 8'd0;
                end else if (bus.fifo_wfull) begin
                    // A full FIFO holds the grant; only the stall counter moves.
                    if (r_stall_count != c_CNT_MAX) begin
                        w_stall_count_nxt = r_stall_count + 16'd1;
                    end
                end else begin
                    w_wr_count_nxt = r_wr_count + 16'd1;
                    if (r_bcnt == c_BCNT_END) begin
                        w_state_nxt = S_IDLE;
                        w_last_nxt  = r_owner;
                        w_bcnt_nxt  = 8'd0;
                    end else begin
                        w_bcnt_nxt = r_bcnt + 8'd1;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_owner       <= '0;
            r_last        <= c_LAST_RST;
            r_bcnt        <= 8'd0;
            r_wr_count    <= 16'd0;
            r_stall_count <= 16'd0;
        end else begin
            r_state       <= w_state_nxt;
            r_owner       <= w_owner_nxt;
            r_last        <= w_last_nxt;
            r_bcnt        <= w_bcnt_nxt;
            r_wr_count    <= w_wr_count_nxt;
            r_stall_count <= w_stall_count_nxt;
        end
    end
endmodule
`default_nettype wire
